// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed, active-low 7-segment scan bus.
// Captures each digit once per stable period and reports complete four-digit frames.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dig,
    input  logic [7:0]  smg,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  blank,
    output logic [3:0]  seg_err,
    output logic        frame_valid,
    output logic [7:0]  frame_cnt
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

    logic [3:0]  samp_dig_q, samp_dig_d;
    logic [7:0]  samp_smg_q, samp_smg_d;
    logic [3:0]  prev_dig_q, prev_dig_d;
    logic [7:0]  prev_smg_q, prev_smg_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cap_done_q, cap_done_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dps_q, dps_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  seg_err_q, seg_err_d;
    logic        frame_valid_q, frame_valid_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic        changed;
    logic        capture;
    logic        frame_done;
    logic [3:0]  sel_oh;
    logic [3:0]  dec_val;
    logic        dec_blank;
    logic        dec_err;

    always_comb begin
        samp_dig_d = dig;
        samp_smg_d = smg;
        prev_dig_d = samp_dig_q;
        prev_smg_d = samp_smg_q;

        changed = (samp_dig_q != prev_dig_q) || (samp_smg_q != prev_smg_q);
        if (changed)
            cnt_d = 8'd0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;

        // The prev stage holds the sample that has been stable for the whole count.
        case (prev_dig_q)
            4'hE:    sel_oh = 4'b0001;
            4'hD:    sel_oh = 4'b0010;
            4'hB:    sel_oh = 4'b0100;
            4'h7:    sel_oh = 4'b1000;
            default: sel_oh = 4'b0000;
        endcase

        capture    = (cnt_q == CNT_MAX) && (sel_oh != 4'b0000) && !cap_done_q;
        cap_done_d = changed ? 1'b0 : (cap_done_q | capture);

        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (prev_smg_q[6:0])
            7'h40:   dec_val = 4'h0;
            7'h79:   dec_val = 4'h1;
            7'h24:   dec_val = 4'h2;
            7'h30:   dec_val = 4'h3;
            7'h19:   dec_val = 4'h4;
            7'h12:   dec_val = 4'h5;
            7'h02:   dec_val = 4'h6;
            7'h78:   dec_val = 4'h7;
            7'h00:   dec_val = 4'h8;
            7'h10:   dec_val = 4'h9;
            7'h08:   dec_val = 4'hA;
            7'h03:   dec_val = 4'hB;
            7'h46:   dec_val = 4'hC;
            7'h21:   dec_val = 4'hD;
            7'h06:   dec_val = 4'hE;
            7'h0E:   dec_val = 4'hF;
            7'h7F: begin
                dec_val   = 4'h0;
                dec_blank = 1'b1;
            end
            default: begin
                dec_val = 4'h0;
                dec_err = 1'b1;
            end
        endcase

        digits_d  = digits_q;
        dps_d     = dps_q;
        blank_d   = blank_q;
        seg_err_d = seg_err_q;
        for (int i = 0; i < 4; i++) begin
            if (capture && sel_oh[i]) begin
                digits_d[4*i +: 4] = dec_val;
                dps_d[i]           = ~prev_smg_q[7];
                blank_d[i]         = dec_blank;
                seg_err_d[i]       = dec_err;
            end
        end

        // A capture landing on the clearing edge starts the next frame.
        frame_done    = (mask_q == 4'hF);
        mask_d        = (frame_done ? 4'h0 : mask_q) | (capture ? sel_oh : 4'h0);
        frame_valid_d = frame_done;
        frame_cnt_d   = frame_done ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_dig_q    <= 4'hF;
            samp_smg_q    <= 8'hFF;
            prev_dig_q    <= 4'hF;
            prev_smg_q    <= 8'hFF;
            cnt_q         <= 8'd0;
            cap_done_q    <= 1'b0;
            mask_q        <= 4'h0;
            digits_q      <= 16'h0000;
            dps_q         <= 4'h0;
            blank_q       <= 4'h0;
            seg_err_q     <= 4'h0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            samp_dig_q    <= samp_dig_d;
            samp_smg_q    <= samp_smg_d;
            prev_dig_q    <= prev_dig_d;
            prev_smg_q    <= prev_smg_d;
            cnt_q         <= cnt_d;
            cap_done_q    <= cap_done_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            dps_q         <= dps_d;
            blank_q       <= blank_d;
            seg_err_q     <= seg_err_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign digits      = digits_q;
    assign dps         = dps_q;
    assign blank       = blank_q;
    assign seg_err     = seg_err_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYC=4: capture timing,
// glyph decode, glitch rejection, frame counting and mid-frame reset.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dig = 4'hF;
    logic [7:0]  smg = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  blank;
    logic [3:0]  seg_err;
    logic        frame_valid;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int fv_cnt = 0;
    int fv_base;
    int n_chg;
    logic [15:0] digits_snap;
    logic [3:0]  dps_snap;

    // active-low a..g patterns for 0..F, dp off
    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_decoder #(.STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dig         (dig),
        .smg         (smg),
        .digits      (digits),
        .dps         (dps),
        .blank       (blank),
        .seg_err     (seg_err),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_cnt++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
        dig = d;
        smg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dig = 4'hF;
        smg = 8'hFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check_val("rst_digits", digits, 16'h0000);
        check_val("rst_dps", dps, 4'h0);
        check_val("rst_blank", blank, 4'h0);
        check_val("rst_seg_err", seg_err, 4'h0);
        check_val("rst_fv", frame_valid, 1'b0);
        check_val("rst_fcnt", frame_cnt, 8'd0);

        // basic scan 0..3
        fv_base = fv_cnt;
        hold(4'hE, 8'hC0, 8);
        hold(4'hD, 8'hF9, 8);
        hold(4'hB, 8'hA4, 8);
        hold(4'h7, 8'hB0, 8);
        check_val("scan_digits", digits, 16'h3210);
        check_val("scan_dps", dps, 4'h0);
        check_val("scan_blank", blank, 4'h0);
        check_val("scan_seg_err", seg_err, 4'h0);
        check_val("scan_fv_pulses", fv_cnt - fv_base, 1);
        check_val("scan_fcnt", frame_cnt, 8'd1);

        // non-one-hot selects never capture
        hold(4'hC, 8'h00, 20);
        check_val("dig_c_digits", digits, 16'h3210);
        check_val("dig_c_dps", dps, 4'h0);
        hold(4'hF, 8'h00, 20);
        check_val("dig_f_digits", digits, 16'h3210);
        check_val("dig_f_dps", dps, 4'h0);

        // blank and illegal patterns
        hold(4'hB, 8'hFF, 8);
        check_val("blank2", blank, 4'b0100);
        check_val("blank2_digits", digits, 16'h3010);
        hold(4'h7, 8'hAA, 8);
        check_val("err3", seg_err, 4'b1000);
        check_val("err3_digits", digits, 16'h0010);
        check_val("err3_dps", dps, 4'h0);

        // latency: new pair first seen at edge k, update at k+5
        hold(4'hE, 8'h92, 8);
        check_val("pre_lat_d0", digits[3:0], 4'h5);
        dig = 4'hE;
        smg = 8'h40;
        repeat (5) @(negedge clk);
        check_val("lat_early_d0", digits[3:0], 4'h5);
        check_val("lat_early_dp0", dps[0], 1'b0);
        @(negedge clk);
        check_val("lat_d0", digits[3:0], 4'h0);
        check_val("lat_dp0", dps[0], 1'b1);
        digits_snap = digits;
        dps_snap = dps;
        n_chg = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (digits !== digits_snap || dps !== dps_snap) n_chg++;
        end
        check_val("hold100_changes", n_chg, 0);

        // every glyph on digit 0
        for (int i = 0; i < 16; i++) begin
            hold(4'hE, glyph[i], 6);
            check_val($sformatf("glyph_%0h", i), {dps[0], seg_err[0], blank[0], digits[3:0]}, {3'b000, 4'(i)});
        end
        hold(4'hE, 8'h03, 6);
        check_val("glyph_b_dp", {dps[0], digits[3:0]}, 5'h1B);

        // 3-cycle glitch on digit 1 is ignored, mask included
        do_reset();
        fv_base = fv_cnt;
        hold(4'hE, 8'hC0, 8);
        hold(4'hD, 8'h80, 3);
        hold(4'hB, 8'hA4, 8);
        hold(4'h7, 8'hB0, 8);
        check_val("glitch_d1", digits[7:4], 4'h0);
        check_val("glitch_dp1", dps[1], 1'b0);
        check_val("glitch_no_frame", fv_cnt - fv_base, 0);
        hold(4'hD, 8'hF9, 8);
        check_val("glitch_frame", fv_cnt - fv_base, 1);
        check_val("glitch_digits", digits, 16'h3210);

        // 257 frames wrap the counter to 1
        do_reset();
        fv_base = fv_cnt;
        for (int f = 0; f < 257; f++) begin
            hold(4'h7, 8'hB0, 6);
            hold(4'hE, 8'hC0, 6);
            hold(4'hB, 8'hA4, 6);
            hold(4'hD, 8'hF9, 6);
        end
        hold(4'hF, 8'hFF, 4);
        check_val("wrap_pulses", fv_cnt - fv_base, 257);
        check_val("wrap_fcnt", frame_cnt, 8'd1);

        // reset mid-frame discards the partial frame
        hold(4'hE, 8'hC0, 8);
        hold(4'hD, 8'hF9, 8);
        hold(4'hB, 8'hA4, 8);
        do_reset();
        check_val("mid_rst_out", {digits, dps, blank, seg_err, frame_valid, frame_cnt}, 41'h0);
        fv_base = fv_cnt;
        hold(4'h7, 8'hB0, 8);
        hold(4'hF, 8'hFF, 4);
        check_val("mid_rst_no_frame", fv_cnt - fv_base, 0);
        check_val("mid_rst_d3", digits, 16'h3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYC, default 4 (legal 2..255), the number of consecutive identical samples of {dig,smg} required before a digit is captured.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 dig  input  4  digit select, active-low; dig[i]=0 selects digit i.
REQ-006 smg  input  8  segments, active-low (0 = lit); smg[7]=dp, smg[6:0]=g,f,e,d,c,b,a.
REQ-007 digits  output  16  decoded hex value per digit; digit i in digits[4i+3:4i].
REQ-008 dps  output  4  decimal point state per digit, 1 = lit.
REQ-009 blank  output  4  1 = digit captured with all of a..g off.
REQ-010 seg_err  output  4  1 = digit captured with a non-glyph a..g pattern.
REQ-011 frame_valid  output  1  one-cycle pulse when all four digits are captured in the current frame.
REQ-012 frame_cnt  output  8  count of completed frames, wraps 255 -> 0.

Function
REQ-013 The block SHALL register {dig,smg} every cycle into a sample stage; all decisions use the sampled values only.
REQ-014 A stability counter SHALL clear to 0 whenever the new sample differs from the previous sample, else increment, saturating at STABLE_CYC-1.
REQ-015 A capture SHALL occur once per stable period: when the counter reaches STABLE_CYC-1, the sampled dig is exactly one-hot-low, and no capture has yet occurred for this unchanged pair; a further capture requires a sample change first.
REQ-016 Samples with dig not one-hot-low (4'hF, or two or more zeros) SHALL never capture; the stability counter still runs.
REQ-017 A pair held fewer than STABLE_CYC consecutive samples (glitch, ghosting during digit switch) SHALL produce no capture.
REQ-018 Capture latency SHALL be exactly STABLE_CYC+1 rising edges from the first edge at which the new pair is present on the ports to the edge at which outputs of digit i update.
REQ-019 Decode of smg[6:0] (hex, active-low) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
REQ-020 smg[6:0]=7F SHALL capture value 0, blank[i]=1, seg_err[i]=0; any other unlisted pattern SHALL capture value 0, blank[i]=0, seg_err[i]=1.
REQ-021 dps[i] SHALL capture ~smg[7] independent of the a..g decode.
REQ-022 On capture of digit i, digits/dps/blank/seg_err for digit i SHALL update on that edge; other digits hold.
REQ-023 A 4-bit seen mask SHALL set bit i on capture of digit i; re-capture of an already-seen digit overwrites its outputs and leaves the mask unchanged.
REQ-024 On the edge after the mask becomes 4'hF, frame_valid SHALL be 1 for exactly one cycle, the mask SHALL clear, and frame_cnt SHALL increment modulo 256.
REQ-025 A capture arriving on the same edge the mask clears SHALL set its mask bit in the new frame (not lost).
REQ-026 Digit order is irrelevant; any scan order completing all four digits forms a frame.

Reset
REQ-027 While rst_n=0 at a rising edge: digits=16'h0000, dps=0, blank=0, seg_err=0, frame_valid=0, frame_cnt=0, mask=0, counter=0, capture flag=0, sample stage dig=4'hF and smg=8'hFF.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid for it after release.
REQ-029 The first capture after reset SHALL follow the full REQ-018 latency.

Verification
REQ-030 Scan digits 0..3 with dig=E,D,B,7 and smg=C0,F9,A4,B0, each held 8 cycles, STABLE_CYC=4 -> digits=16'h3210, dps=0, blank=0, seg_err=0, frame_valid one pulse, frame_cnt=1.
REQ-031 Hold dig=E, smg=40 (dp lit, 0) from edge k -> digits[3:0]=0 and dps[0]=1 at edge k+5, not earlier; holding 100 further cycles causes no further capture.
REQ-032 Glitch dig=D, smg=80 for 3 cycles between stable digits -> digit 1 outputs and mask unchanged.
REQ-033 dig=C (two digits) or F held 20 cycles -> no output change; smg=FF on dig=B -> blank[2]=1; smg=AA on dig=7 -> seg_err[3]=1, digits[15:12]=0.
REQ-034 Complete 257 frames -> frame_cnt=1 and 257 frame_valid pulses; assert rst_n=0 after 3 of 4 digits captured -> all outputs zero, completing the 4th digit after release yields no frame_valid.
